timing_instr_fifo: RTL and testbench



---
 rtl/timing_instr_fifo.sv | 96 +++++++++
 tb/tb_timing_instr_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/timing_instr_fifo.sv
// First-word-fall-through instruction queue feeding the timing control unit.
// Head entry, level and flags are all registered so the consumer sees clean outputs.
module timing_instr_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              we,
   input  logic [7:0]        wdata,
   output logic              full,
   input  logic              re,
   output logic [7:0]        pop,
   output logic              fifo_empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   input  logic              clr_ovf
);

   logic [7:0]      mem_q [DEPTH];
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] level_q, level_d;
   logic [7:0]      pop_q, pop_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            ovf_q, ovf_d;
   logic            wr_en, rd_en;

   always_comb begin
      wr_en    = we && !full_q && !flush;
      rd_en    = re && !empty_q && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      end

      level_d = wr_ptr_d - rd_ptr_d;
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {ADDR_W{1'b0}}});

      // When the next head is the slot being written this cycle, bypass the array.
      pop_d = 8'h00;
      if (!empty_d) begin
         if (wr_en && (wr_ptr_q == rd_ptr_d))
            pop_d = wdata;
         else
            pop_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
      end

      ovf_d = ovf_q;
      if (we && full_q && !flush)
         ovf_d = 1'b1;
      else if (clr_ovf)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         pop_q    <= 8'h00;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         pop_q    <= pop_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
   end

   assign full       = full_q;
   assign fifo_empty = empty_q;
   assign level      = level_q;
   assign pop        = pop_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_timing_instr_fifo.sv
// Self-checking bench for timing_instr_fifo: table vectors, corner-case sequences
// and randomized traffic compared against a queue-based reference model.
module tb_timing_instr_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              we = 1'b0;
   logic [7:0]        wdata = 8'h00;
   logic              full;
   logic              re = 1'b0;
   logic [7:0]        pop;
   logic              fifo_empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              clr_ovf = 1'b0;

   int errors = 0;
   int checks = 0;
   int txn    = 0;

   logic [7:0] mq[$];
   bit         mov = 1'b0;

   always #5 clk = ~clk;

   timing_instr_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .we(we), .wdata(wdata),
      .full(full), .re(re), .pop(pop), .fifo_empty(fifo_empty),
      .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   typedef struct {
      logic       r, f, w;
      logic [7:0] d;
      logic       rd, c;
      logic [7:0] e_pop;
      logic       e_empty, e_full;
      int         e_level;
      logic       e_ovf;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
      end
   endtask

   // Reference model: plain queue semantics evaluated on pre-edge state.
   task automatic model_update(input logic r, f, w, input logic [7:0] d, input logic rd, c);
      bit was_full;
      bit has;
      if (r) begin
         mq.delete();
         mov = 1'b0;
      end else if (f) begin
         mq.delete();
         if (c) mov = 1'b0;
      end else begin
         was_full = (mq.size() == DEPTH);
         has      = (mq.size() > 0);
         if (w && was_full) mov = 1'b1;
         else if (c) mov = 1'b0;
         if (rd && has) void'(mq.pop_front());
         if (w && !was_full) mq.push_back(d);
      end
   endtask

   task automatic step(input logic r, f, w, input logic [7:0] d, input logic rd, c);
      logic [7:0] e_pop;
      rst = r; flush = f; we = w; wdata = d; re = rd; clr_ovf = c;
      model_update(r, f, w, d, rd, c);
      @(posedge clk);
      #1;
      txn++;
      e_pop = (mq.size() > 0) ? mq[0] : 8'h00;
      chk("pop",        int'(pop),        int'(e_pop));
      chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
      chk("full",       int'(full),       int'(mq.size() == DEPTH));
      chk("level",      int'(level),      mq.size());
      chk("overflow",   int'(overflow),   int'(mov));
      $display("txn %0d rst=%b flush=%b we=%b wdata=%02h re=%b clr=%b -> pop=%02h empty=%b full=%b level=%0d ovf=%b",
               txn, r, f, w, d, rd, c, pop, fifo_empty, full, level, overflow);
   endtask

   task automatic wr(input logic [7:0] d);
      step(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic rdx();
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   vec_t vecs[10];

   initial begin
      //        r  f  w  d      rd c   pop    emp full lvl ovf
      vecs[0] = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0};
      vecs[1] = '{0, 0, 1, 8'h85, 0, 0, 8'h85, 0, 0, 1, 0};
      vecs[2] = '{0, 0, 1, 8'h03, 0, 0, 8'h85, 0, 0, 2, 0};
      vecs[3] = '{0, 0, 0, 8'h00, 1, 0, 8'h03, 0, 0, 1, 0};
      vecs[4] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0};
      vecs[5] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0};
      vecs[6] = '{0, 0, 1, 8'h55, 0, 0, 8'h55, 0, 0, 1, 0};
      vecs[7] = '{0, 0, 1, 8'h12, 1, 0, 8'h12, 0, 0, 1, 0};
      vecs[8] = '{0, 0, 1, 8'h00, 0, 0, 8'h12, 0, 0, 2, 0};
      vecs[9] = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].r, vecs[i].f, vecs[i].w, vecs[i].d, vecs[i].rd, vecs[i].c);
         chk("tbl_pop",   int'(pop),        int'(vecs[i].e_pop));
         chk("tbl_empty", int'(fifo_empty), int'(vecs[i].e_empty));
         chk("tbl_full",  int'(full),       int'(vecs[i].e_full));
         chk("tbl_level", int'(level),      vecs[i].e_level);
         chk("tbl_ovf",   int'(overflow),   int'(vecs[i].e_ovf));
      end

      // Fill to DEPTH, overflow on the 17th write, drain in order.
      for (int i = 0; i < DEPTH; i++) wr(8'h80 + 8'(i));
      chk("fill_full",  int'(full),  1);
      chk("fill_level", int'(level), 16);
      wr(8'hAA);
      chk("ovf_set",    int'(overflow), 1);
      chk("ovf_level",  int'(level),    16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", int'(pop), 8'h80 + i);
         rdx();
      end
      chk("drain_empty", int'(fifo_empty), 1);
      chk("drain_pop",   int'(pop),        0);

      // Full queue with simultaneous write and pop: write dropped.
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", int'(overflow), 0);
      for (int i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i));
      step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("fullrw_level", int'(level),    15);
      chk("fullrw_ovf",   int'(overflow), 1);
      chk("fullrw_pop",   int'(pop),      8'h41);
      for (int i = 0; i < DEPTH - 1; i++) begin
         chk("fullrw_no77", int'(pop == 8'h77), 0);
         rdx();
      end

      // Pointer wrap with interleaved write/pop.
      wr(8'h00);
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
         chk("wrap_pop",   int'(pop),         i);
         chk("wrap_level", int'(level <= 2),  1);
      end
      rdx();

      // Flush keeps overflow, clr_ovf clears it, reset discards contents.
      for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
      chk("pre_flush_ovf", int'(overflow), 1);
      step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
      chk("flush_level", int'(level),      0);
      chk("flush_empty", int'(fifo_empty), 1);
      chk("flush_pop",   int'(pop),        0);
      chk("flush_ovf",   int'(overflow),   1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_after_flush", int'(overflow), 0);
      for (int i = 0; i < 3; i++) wr(8'h20 + 8'(i));
      step(1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
      chk("rst_level", int'(level),      0);
      chk("rst_empty", int'(fifo_empty), 1);
      chk("rst_pop",   int'(pop),        0);

      // Randomized traffic with alternating fill/drain bias.
      for (int i = 0; i < 300; i++) begin
         logic       r, f, w, rd, c;
         logic [7:0] d;
         bit         fill_bias;
         fill_bias = ((i / 40) % 2) == 0;
         r  = ($urandom_range(0, 199) == 0);
         f  = ($urandom_range(0, 59) == 0);
         w  = ($urandom_range(0, 99) < (fill_bias ? 75 : 35));
         rd = ($urandom_range(0, 99) < (fill_bias ? 30 : 70));
         c  = ($urandom_range(0, 19) == 0);
         d  = 8'($urandom);
         step(r, f, w, d, rd, c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
